subtraction_sequential_unit: RTL and testbench

//  Multi-cycle IEEE-754 single-precision subtractor, result = floating1_in - floating2_in.
//  It is the subtract-direction counterpart to the combinational addition path.

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/magnitude_swapper.sv | 34 +++
 rtl/subtraction_sequential_unit.sv | 176 +++++++++++++++++
 tb/tb_subtraction_sequential_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field widths, special encodings, FSM states and the
// unpacked operand record used by the sequential subtractor.
package fpu_pkg;

  localparam int FP_DATA_WIDTH = 32;
  localparam int FP_MENT_WIDTH = 23;
  localparam int FP_EXPO_WIDTH = 8;
  localparam int SIG_WIDTH     = FP_MENT_WIDTH + 1;
  localparam int SUM_WIDTH     = SIG_WIDTH + 1;
  localparam int CNT_WIDTH     = 5;
  localparam int ALIGN_CLAMP   = 25;

  localparam logic [FP_DATA_WIDTH-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [FP_EXPO_WIDTH-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    OPER,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic                     sign;
    logic [FP_EXPO_WIDTH-1:0] exp;
    logic [SIG_WIDTH-1:0]     sig;
  } operand_t;

  function automatic logic [FP_DATA_WIDTH-1:0] pack_fp(
    input logic                     sign,
    input logic [FP_EXPO_WIDTH-1:0] exp,
    input logic [FP_MENT_WIDTH-1:0] frac
  );
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/magnitude_swapper.sv
// Orders two unpacked operands by magnitude and derives the result sign,
// the effective operation and the clamped exponent difference.
module magnitude_swapper
  import fpu_pkg::*;
(
  input  operand_t                 a_in,
  input  operand_t                 b_in,
  output logic [FP_EXPO_WIDTH-1:0] l_exp_out,
  output logic [SIG_WIDTH-1:0]     l_sig_out,
  output logic [SIG_WIDTH-1:0]     s_sig_out,
  output logic                     sign_res_out,
  output logic                     eff_sub_out,
  output logic [CNT_WIDTH-1:0]     diff_out
);

  logic                     a_ge;
  logic [FP_EXPO_WIDTH-1:0] s_exp;
  logic [FP_EXPO_WIDTH-1:0] exp_diff;

  always_comb begin
    // Ties keep a as the larger operand.
    a_ge         = {a_in.exp, a_in.sig} >= {b_in.exp, b_in.sig};
    l_exp_out    = a_ge ? a_in.exp  : b_in.exp;
    l_sig_out    = a_ge ? a_in.sig  : b_in.sig;
    sign_res_out = a_ge ? a_in.sign : b_in.sign;
    s_exp        = a_ge ? b_in.exp  : a_in.exp;
    s_sig_out    = a_ge ? b_in.sig  : a_in.sig;
    eff_sub_out  = a_in.sign != b_in.sign;
    exp_diff     = l_exp_out - s_exp;
    diff_out     = (exp_diff > FP_EXPO_WIDTH'(ALIGN_CLAMP)) ? CNT_WIDTH'(ALIGN_CLAMP)
                                                          : exp_diff[CNT_WIDTH-1:0];
  end

endmodule

// File: rtl/subtraction_sequential_unit.sv
// Multi-cycle single-precision subtractor (a - b computed as a + (-b)) with a
// one-bit-per-cycle aligner and normaliser around a shared 25-bit adder.
module subtraction_sequential_unit
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = FP_DATA_WIDTH,
  parameter int MENT_WIDTH = FP_MENT_WIDTH,
  parameter int EXPO_WIDTH = FP_EXPO_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  resetn_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  input  logic [DATA_WIDTH-1:0] floating1_in,
  input  logic [DATA_WIDTH-1:0] floating2_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [DATA_WIDTH-1:0] result_out
);

  localparam logic [FP_EXPO_WIDTH-1:0] EXP_TOP = EXP_MAX - 8'd1;

  state_t                   state_q, state_d;
  logic [FP_EXPO_WIDTH-1:0] exp_q, exp_d;
  logic [SIG_WIDTH-1:0]     l_sig_q, l_sig_d;
  logic [SIG_WIDTH-1:0]     s_sig_q, s_sig_d;
  logic [SUM_WIDTH-1:0]     sum_q, sum_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     sign_q, sign_d;
  logic                     eff_sub_q, eff_sub_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    result_q, result_d;

  operand_t                 a_op, b_op;
  logic                     any_nan;
  logic [FP_EXPO_WIDTH-1:0] sw_l_exp;
  logic [SIG_WIDTH-1:0]     sw_l_sig, sw_s_sig;
  logic                     sw_sign, sw_eff_sub;
  logic [CNT_WIDTH-1:0]     sw_diff;

  // Zero exponent flushes the operand to zero; b's sign is flipped here.
  always_comb begin
    a_op.sign = floating1_in[DATA_WIDTH-1];
    a_op.exp  = floating1_in[MENT_WIDTH +: EXPO_WIDTH];
    a_op.sig  = (a_op.exp == '0) ? '0 : {1'b1, floating1_in[MENT_WIDTH-1:0]};
    b_op.sign = ~floating2_in[DATA_WIDTH-1];
    b_op.exp  = floating2_in[MENT_WIDTH +: EXPO_WIDTH];
    b_op.sig  = (b_op.exp == '0) ? '0 : {1'b1, floating2_in[MENT_WIDTH-1:0]};
    any_nan   = (a_op.exp == EXP_MAX) || (b_op.exp == EXP_MAX);
  end

  magnitude_swapper u_swapper (
    .a_in         (a_op),
    .b_in         (b_op),
    .l_exp_out    (sw_l_exp),
    .l_sig_out    (sw_l_sig),
    .s_sig_out    (sw_s_sig),
    .sign_res_out (sw_sign),
    .eff_sub_out  (sw_eff_sub),
    .diff_out     (sw_diff)
  );

  assign in_ready_out  = resetn_in && (state_q == IDLE);
  assign out_valid_out = out_valid_q;
  assign result_out    = result_q;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    l_sig_d     = l_sig_q;
    s_sig_d     = s_sig_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    eff_sub_d   = eff_sub_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid_in && in_ready_out) begin
          if (any_nan) begin
            result_d    = QNAN;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            exp_d     = sw_l_exp;
            l_sig_d   = sw_l_sig;
            s_sig_d   = sw_s_sig;
            sign_d    = sw_sign;
            eff_sub_d = sw_eff_sub;
            cnt_d     = sw_diff;
            state_d   = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (cnt_q != '0) begin
          s_sig_d = s_sig_q >> 1;
          cnt_d   = cnt_q - CNT_WIDTH'(1);
        end
        if (cnt_q <= CNT_WIDTH'(1)) begin
          state_d = OPER;
        end
      end

      OPER: begin
        // L >= S in magnitude, so the subtract never borrows.
        sum_d   = eff_sub_q ? ({1'b0, l_sig_q} - {1'b0, s_sig_q})
                            : ({1'b0, l_sig_q} + {1'b0, s_sig_q});
        state_d = NORM;
      end

      NORM: begin
        if (sum_q[SUM_WIDTH-1]) begin
          result_d    = (exp_q == EXP_TOP) ? pack_fp(sign_q, EXP_MAX, '0)
                                           : pack_fp(sign_q, exp_q + 8'd1, sum_q[SIG_WIDTH-1:1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (sum_q == '0) begin
          result_d    = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (sum_q[SIG_WIDTH-1]) begin
          result_d    = pack_fp(sign_q, exp_q, sum_q[FP_MENT_WIDTH-1:0]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (exp_q == 8'd1) begin
          result_d    = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          sum_d = {sum_q[SUM_WIDTH-2:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end

      DONE: begin
        if (out_ready_in) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!resetn_in) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      l_sig_q     <= '0;
      s_sig_q     <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      l_sig_q     <= l_sig_d;
      s_sig_q     <= s_sig_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      eff_sub_q   <= eff_sub_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: tb/tb_subtraction_sequential_unit.sv
// Directed bench for subtraction_sequential_unit: an integer-arithmetic model
// predicts result and latency; a per-cycle monitor checks the live outputs.
module tb_subtraction_sequential_unit;

  logic        clk_in = 1'b0;
  logic        resetn_in = 1'b0;
  logic        in_valid_in = 1'b0;
  logic        in_ready_out;
  logic [31:0] floating1_in = '0;
  logic [31:0] floating2_in = '0;
  logic        out_valid_out;
  logic        out_ready_in = 1'b0;
  logic [31:0] result_out;

  subtraction_sequential_unit dut (
    .clk_in        (clk_in),
    .resetn_in     (resetn_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .floating1_in  (floating1_in),
    .floating2_in  (floating2_in),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .result_out    (result_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endfunction

  // Result and number of clock edges after the accept edge before out_valid is seen.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    int ea, eb, ma, mb, el, es, ml, ms, d, sum, e, n;
    logic sa, sb, sl;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) begin
      r = 32'h7FC0_0000;
      lat = 0;
      return;
    end
    ma = (ea == 0) ? 0 : int'(a[22:0]) + (1 << 23);
    mb = (eb == 0) ? 0 : int'(b[22:0]) + (1 << 23);
    sa = a[31];
    sb = !b[31];
    if (ea > eb || (ea == eb && ma >= mb)) begin
      el = ea; ml = ma; es = eb; ms = mb; sl = sa;
    end else begin
      el = eb; ml = mb; es = ea; ms = ma; sl = sb;
    end
    d = el - es;
    if (d > 25) d = 25;
    ms = ms >> d;
    sum = (sa != sb) ? ml - ms : ml + ms;
    e = el;
    n = 0;
    if (sum >= (1 << 24)) begin
      e++;
      r = (e >= 255) ? {sl, 8'hFF, 23'h0} : {sl, 8'(e), 23'(sum >> 1)};
    end else begin
      while (sum != 0 && sum < (1 << 23) && e > 1) begin
        sum = sum * 2;
        e--;
        n++;
      end
      r = (sum >= (1 << 23)) ? {sl, 8'(e), 23'(sum)} : 32'h0;
    end
    lat = ((d < 1) ? 1 : d) + 1 + n + 1;
  endfunction

  logic [31:0] exp_res;
  int          exp_lat;
  int          elapsed;
  bit          mon_active = 1'b0;

  // Every cycle an operation is outstanding: valid timing, busy flag and result.
  always @(negedge clk_in) begin
    if (mon_active) begin
      chk($sformatf("out_valid@%0d", elapsed), {31'b0, out_valid_out},
          {31'b0, (elapsed >= exp_lat)});
      chk($sformatf("in_ready_busy@%0d", elapsed), {31'b0, in_ready_out}, 32'h0);
      if (out_valid_out) chk($sformatf("result@%0d", elapsed), result_out, exp_res);
      elapsed++;
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] r;
    int          l;
    bit          got;
    model(a, b, r, l);
    @(negedge clk_in);
    chk("in_ready_idle", {31'b0, in_ready_out}, 32'h1);
    floating1_in = a;
    floating2_in = b;
    in_valid_in  = 1'b1;
    @(posedge clk_in);
    #1;
    // Keep valid asserted with junk operands while busy; they must be ignored.
    floating1_in = $urandom;
    floating2_in = $urandom;
    exp_res      = r;
    exp_lat      = l;
    elapsed      = 0;
    mon_active   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_in);
      if (out_valid_out) got = 1'b1;
    end
    chk("result_arrives", {31'b0, out_valid_out}, 32'h1);
    repeat (hold) @(negedge clk_in);
    out_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    out_ready_in = 1'b0;
    in_valid_in  = 1'b0;
    mon_active   = 1'b0;
    @(negedge clk_in);
    chk("valid_after_hs", {31'b0, out_valid_out}, 32'h0);
    chk("ready_after_hs", {31'b0, in_ready_out}, 32'h1);
    $display("op %h - %h -> %h (expect %h, latency %0d, hold %0d)", a, b, result_out, r, l, hold);
  endtask

  task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r_lit, input int lat_lit, input int hold);
    logic [31:0] r;
    int          l;
    model(a, b, r, l);
    chk($sformatf("model_res %h-%h", a, b), r, r_lit);
    chk($sformatf("model_lat %h-%h", a, b), 32'(l), 32'(lat_lit));
    do_op(a, b, hold);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_out_valid", {31'b0, out_valid_out}, 32'h0);
    chk("rst_result", result_out, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready_out}, 32'h0);
    resetn_in = 1'b1;
    @(negedge clk_in);
    chk("post_rst_ready", {31'b0, in_ready_out}, 32'h1);

    run_vec(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000,  3, 0);
    run_vec(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,  3, 0);
    run_vec(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,  3, 0);
    run_vec(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000,  3, 0);
    run_vec(32'h3F80_0000, 32'h3FC0_0000, 32'hBF00_0000,  4, 0);
    run_vec(32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 27, 0);
    run_vec(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000,  0, 0);
    run_vec(32'h0080_0000, 32'h00C0_0000, 32'h0000_0000,  3, 0);
    run_vec(32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 27, 0);
    run_vec(32'h0040_0000, 32'h0000_0000, 32'h0000_0000,  3, 0);
    run_vec(32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000, 26, 0);
    run_vec(32'h3F80_0000, 32'h3FC0_0000, 32'hBF00_0000,  4, 5);

    // Abort a long operation with reset while it is still aligning.
    @(negedge clk_in);
    floating1_in = 32'h3F80_0000;
    floating2_in = 32'h3080_0000;
    in_valid_in  = 1'b1;
    @(posedge clk_in);
    #1;
    in_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("busy_before_abort", {31'b0, in_ready_out}, 32'h0);
    resetn_in = 1'b0;
    @(negedge clk_in);
    chk("abort_in_ready", {31'b0, in_ready_out}, 32'h0);
    chk("abort_out_valid", {31'b0, out_valid_out}, 32'h0);
    chk("abort_result", result_out, 32'h0);
    resetn_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      chk($sformatf("abort_quiet_valid@%0d", i), {31'b0, out_valid_out}, 32'h0);
      chk($sformatf("abort_quiet_ready@%0d", i), {31'b0, in_ready_out}, 32'h1);
    end
    $display("op 3f800000 - 30800000 aborted by reset during align");

    run_vec(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
